// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register.
// Keeps at most one imem request in flight and handles stalls and redirects from EX.
module fetch_stage #(
    parameter int               XLEN      = 32,
    parameter logic [XLEN-1:0]  RESET_PC  = '0,
    parameter logic [31:0]      NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imemReq,
    output logic [XLEN-1:0] imemAddr,
    input  logic            imemReady,
    input  logic            imemValid,
    input  logic [31:0]     imemRdata,
    input  logic            stallD,
    input  logic            flushD,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    output logic [31:0]     instrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            validD
);

    // state   | meaning
    // S_REQ   | request for PCF is presented to imem
    // S_WAIT  | request accepted, waiting for read data
    // S_HOLD  | data returned during a decode stall, parked in the hold buffer
    // S_DRAIN | redirect hit while waiting; the stale response is discarded
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DRAIN} state_t;

    state_t          state, state_nxt;
    logic [XLEN-1:0] pcf, pcf_nxt;
    logic [XLEN-1:0] redirect_pc;
    logic [31:0]     hold_instr;
    logic [XLEN-1:0] hold_pc;
    logic            hold_ld;
    logic            new_v;
    logic [31:0]     new_instr;
    logic [XLEN-1:0] new_pc;

    assign redirect_pc = PCTargetE & ~XLEN'(3);
    assign imemReq     = (state == S_REQ) && !PCSrcE;
    assign imemAddr    = pcf;

    always_comb begin
        state_nxt = state;
        pcf_nxt   = pcf;
        hold_ld   = 1'b0;
        new_v     = 1'b0;
        new_instr = imemRdata;
        new_pc    = pcf;
        case (state)
            S_REQ: begin
                if (!PCSrcE && imemReady) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (PCSrcE) begin
                    state_nxt = imemValid ? S_REQ : S_DRAIN;
                end else if (imemValid) begin
                    pcf_nxt = pcf + XLEN'(4);
                    if (stallD) begin
                        state_nxt = S_HOLD;
                        hold_ld   = 1'b1;
                    end else begin
                        state_nxt = S_REQ;
                        new_v     = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (PCSrcE) begin
                    state_nxt = S_REQ;
                end else if (!stallD) begin
                    state_nxt = S_REQ;
                    new_v     = 1'b1;
                    new_instr = hold_instr;
                    new_pc    = hold_pc;
                end
            end
            S_DRAIN: begin
                if (imemValid) state_nxt = S_REQ;
            end
        endcase
        // A redirect overrides any sequential advance of PCF
        if (PCSrcE) pcf_nxt = redirect_pc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_REQ;
            pcf        <= RESET_PC;
            hold_instr <= '0;
            hold_pc    <= '0;
        end else begin
            state <= state_nxt;
            pcf   <= pcf_nxt;
            if (hold_ld) begin
                hold_instr <= imemRdata;
                hold_pc    <= pcf;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instrD   <= NOP_INSTR;
            PCD      <= '0;
            PCPlus4D <= '0;
            validD   <= 1'b0;
        end else if (flushD || PCSrcE) begin
            instrD <= NOP_INSTR;
            validD <= 1'b0;
        end else if (stallD) begin
            instrD   <= instrD;
            PCD      <= PCD;
            PCPlus4D <= PCPlus4D;
            validD   <= validD;
        end else if (new_v) begin
            instrD   <= new_instr;
            PCD      <= new_pc;
            PCPlus4D <= new_pc + XLEN'(4);
            validD   <= 1'b1;
        end else begin
            instrD <= NOP_INSTR;
            validD <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: program-order scoreboard plus a random-latency imem responder.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        imemReq, imemReady, imemValid;
    logic [31:0] imemAddr, imemRdata;
    logic        stallD, flushD, PCSrcE;
    logic [31:0] PCTargetE;
    logic [31:0] instrD, PCD, PCPlus4D;
    logic        validD;

    logic        w_req, w_ready, w_valid, w_validD;
    logic [31:0] w_addr, w_rdata, w_instrD, w_PCD, w_PCPlus4D;

    fetch_stage dut (
        .clk(clk), .rst(rst),
        .imemReq(imemReq), .imemAddr(imemAddr), .imemReady(imemReady),
        .imemValid(imemValid), .imemRdata(imemRdata),
        .stallD(stallD), .flushD(flushD), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .instrD(instrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .validD(validD)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .rst(rst),
        .imemReq(w_req), .imemAddr(w_addr), .imemReady(w_ready),
        .imemValid(w_valid), .imemRdata(w_rdata),
        .stallD(stallD), .flushD(flushD), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .instrD(w_instrD), .PCD(w_PCD), .PCPlus4D(w_PCPlus4D), .validD(w_validD)
    );

    int total = 0;
    int bad   = 0;

    // Reference: memory contents, one outstanding request, and program order
    logic        out_v;
    logic [31:0] out_addr;
    int          out_cnt;
    logic [31:0] fetch_exp, deliver_exp;
    int          ndeliv;
    int          lat_min, lat_max, ready_pct;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[29:0], 2'b11} ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        stallD    = 1'b0;
        flushD    = 1'b0;
        PCSrcE    = 1'b0;
        PCTargetE = '0;
        imemValid = 1'b0;
        imemReady = 1'b0;
        imemRdata = '0;
        @(posedge clk);
        #1;
        rst         = 1'b0;
        out_v       = 1'b0;
        out_cnt     = 0;
        fetch_exp   = 32'h0;
        deliver_exp = 32'h0;
        ndeliv      = 0;
    endtask

    // One clock: drive inputs, respond as imem, score IF/ID, advance to next edge
    task automatic step(input logic s, input logic f, input logic p, input logic [31:0] t);
        logic resp, acc;
        stallD    = s;
        flushD    = f;
        PCSrcE    = p;
        PCTargetE = t;
        resp      = out_v && (out_cnt == 1);
        imemValid = resp;
        imemRdata = resp ? memf(out_addr) : $urandom();
        imemReady = ($urandom_range(99) < ready_pct);
        #1;
        acc = imemReq && imemReady;
        if (imemReq) chk("single_outstanding", 32'(out_v), 32'd0);
        if (acc) begin
            chk("fetch_addr", imemAddr, fetch_exp);
            fetch_exp += 32'd4;
        end
        if (!validD) begin
            chk("bubble_nop", instrD, NOP);
        end else if (!s && !f && !p) begin
            chk("deliver_pc", PCD, deliver_exp);
            chk("deliver_instr", instrD, memf(deliver_exp));
            chk("deliver_pc4", PCPlus4D, deliver_exp + 32'd4);
            deliver_exp += 32'd4;
            ndeliv++;
        end else if (f && !p) begin
            deliver_exp += 32'd4;
        end
        if (p) begin
            fetch_exp   = t & ~32'd3;
            deliver_exp = fetch_exp;
        end
        if (resp) out_v = 1'b0;
        else if (out_v) out_cnt--;
        if (acc) begin
            out_v    = 1'b1;
            out_addr = imemAddr;
            out_cnt  = int'($urandom_range(lat_max, lat_min));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic found;
        w_ready = 1'b0;
        w_valid = 1'b0;
        w_rdata = '0;

        // Reset values and 1-cycle memory streaming
        lat_min = 1; lat_max = 1; ready_pct = 100;
        do_reset();
        chk("rst_instr", instrD, NOP);
        chk("rst_pcd", PCD, 32'h0);
        chk("rst_pc4", PCPlus4D, 32'h0);
        chk("rst_valid", 32'(validD), 32'd0);
        chk("rst_req", 32'(imemReq), 32'd1);
        chk("rst_addr", imemAddr, 32'h0);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("t1_throughput", 32'(ndeliv), 32'd9);

        // PC wrap at the top of the address space
        do_reset();
        chk("t5_addr0", w_addr, 32'hFFFF_FFFC);
        chk("t5_req0", 32'(w_req), 32'd1);
        w_ready = 1'b1;
        step(1'b0, 1'b0, 1'b0, 32'h0);
        w_ready = 1'b0;
        w_valid = 1'b1;
        w_rdata = 32'hABCD_0013;
        step(1'b0, 1'b0, 1'b0, 32'h0);
        w_valid = 1'b0;
        chk("t5_valid", 32'(w_validD), 32'd1);
        chk("t5_instr", w_instrD, 32'hABCD_0013);
        chk("t5_pcd", w_PCD, 32'hFFFF_FFFC);
        chk("t5_pc4", w_PCPlus4D, 32'h0);
        chk("t5_addr1", w_addr, 32'h0);
        chk("t5_req1", 32'(w_req), 32'd1);

        // Stall across data return: buffered, released exactly once
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            if (out_v && out_cnt == 1) found = 1'b1;
            else step(1'b0, 1'b0, 1'b0, 32'h0);
        end
        chk("t2_found_wait", 32'(found), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b0, 32'h0);
            chk("t2_hold_req", 32'(imemReq), 32'd0);
            chk("t2_hold_valid", 32'(validD), 32'd0);
        end
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("t2_release_valid", 32'(validD), 32'd1);
        chk("t2_release_pc", PCD, deliver_exp);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("t2_no_dup", 32'(validD), 32'd0);

        // Redirect while waiting on a slow memory
        lat_min = 3; lat_max = 3;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (out_v && out_cnt >= 2) found = 1'b1;
            else step(1'b0, 1'b0, 1'b0, 32'h0);
        end
        chk("t3_found_wait", 32'(found), 32'd1);
        step(1'b0, 1'b0, 1'b1, 32'h0000_0103);
        found = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            if (validD) found = 1'b1;
            else step(1'b0, 1'b0, 1'b0, 32'h0);
        end
        chk("t3_found_valid", 32'(found), 32'd1);
        chk("t3_pcd", PCD, 32'h0000_0100);
        chk("t3_instr", instrD, memf(32'h0000_0100));

        // Flush wins over stall
        lat_min = 1; lat_max = 1;
        step(1'b0, 1'b0, 1'b0, 32'h0);
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            if (validD) found = 1'b1;
            else step(1'b0, 1'b0, 1'b0, 32'h0);
        end
        chk("t4_found_valid", 32'(found), 32'd1);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("t4_stall_keep", 32'(validD), 32'd1);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("t4_flush_valid", 32'(validD), 32'd0);
        chk("t4_flush_instr", instrD, NOP);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 32'h0);

        // Reset in the middle of a pending fetch
        lat_min = 3; lat_max = 3;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            if (out_v) found = 1'b1;
            else step(1'b0, 1'b0, 1'b0, 32'h0);
        end
        chk("t6_found_wait", 32'(found), 32'd1);
        do_reset();
        chk("t6_addr", imemAddr, 32'h0);
        chk("t6_valid", 32'(validD), 32'd0);
        chk("t6_req", 32'(imemReq), 32'd1);

        // Random traffic
        lat_min = 1; lat_max = 3; ready_pct = 70;
        for (int i = 0; i < 1500; i++) begin
            logic s, p, f;
            logic [31:0] t;
            s = ($urandom_range(99) < 25);
            p = ($urandom_range(99) < 4);
            f = p && $urandom_range(1) == 1;
            t = $urandom_range(4095);
            step(s, f, p, t);
        end
        chk("rand_progress", 32'(ndeliv >= 100), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
